// File: rtl/row_buffer_ctrl_if.sv
// Pixel-stream and column-tag bundle between the upstream source, the row-buffer
// sequencing controller and the downstream window stage.
interface row_buffer_ctrl_if #(
   parameter int PIX_BIT = 8,
   parameter int XW      = 9,
   parameter int YW      = 8
);
   logic [PIX_BIT-1:0] in_pix;
   logic               in_valid;
   logic               in_sof;
   logic               in_ready;
   logic [PIX_BIT-1:0] buf_pix;
   logic               buf_pix_valid;
   logic               sel_top_row;
   logic [1:0]         sel_btm_row;
   logic               col_valid;
   logic [XW-1:0]      col_x;
   logic [YW-1:0]      col_y;
   logic               col_eol;
   logic               col_eof;
   logic               frame_done;
   logic               sof_err;

   modport slave (
      input  in_pix, in_valid, in_sof,
      output in_ready, buf_pix, buf_pix_valid, sel_top_row, sel_btm_row,
             col_valid, col_x, col_y, col_eol, col_eof, frame_done, sof_err
   );

   modport master (
      output in_pix, in_valid, in_sof,
      input  in_ready, buf_pix, buf_pix_valid, sel_top_row, sel_btm_row,
             col_valid, col_x, col_y, col_eol, col_eof, frame_done, sof_err
   );
endinterface

// File: rtl/row_buffer_ctrl.sv
// Write-side sequencer for the 7x7 row-buffer array: forwards the raster stream,
// drives border mirror selects, appends three flush rows and tags window columns.
module row_buffer_ctrl #(
   parameter int ROW_WIDTH  = 340,
   parameter int NUM_ROWS   = 240,
   parameter int PIX_BIT    = 8,
   parameter int MASK_WIDTH = 7
) (
   input logic              clk,
   input logic              reset,
   row_buffer_ctrl_if.slave bus
);
   localparam int XW = $clog2(ROW_WIDTH);
   localparam int YW = $clog2(NUM_ROWS);
   localparam logic [XW-1:0] X_LAST = XW'(ROW_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(NUM_ROWS - 1);

   if (MASK_WIDTH != 7) begin : g_mask_check
      $error("row_buffer_ctrl supports MASK_WIDTH=7 only");
   end

   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_TOP, S_STREAM, S_FLUSH, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [1:0]         k_q, k_d;
   logic               in_ready_q, in_ready_d;
   logic [PIX_BIT-1:0] buf_pix_q, buf_pix_d;
   logic               buf_pix_valid_q, buf_pix_valid_d;
   logic               sel_top_q, sel_top_d;
   logic [1:0]         sel_btm_q, sel_btm_d;
   logic               col_valid_q, col_valid_d;
   logic [XW-1:0]      col_x_q, col_x_d;
   logic [YW-1:0]      col_y_q, col_y_d;
   logic               col_eol_q, col_eol_d;
   logic               col_eof_q, col_eof_d;
   logic               frame_done_q, frame_done_d;
   logic               sof_err_q, sof_err_d;
   logic               accept;
   logic               row_end;

   always_comb begin
      accept          = bus.in_valid && in_ready_q;
      row_end         = (x_q == X_LAST);
      state_d         = state_q;
      x_d             = x_q;
      y_d             = y_q;
      k_d             = k_q;
      buf_pix_d       = buf_pix_q;
      buf_pix_valid_d = 1'b0;
      sel_top_d       = sel_top_q;
      sel_btm_d       = sel_btm_q;
      col_valid_d     = 1'b0;
      col_x_d         = col_x_q;
      col_y_d         = col_y_q;
      col_eol_d       = 1'b0;
      col_eof_d       = 1'b0;
      frame_done_d    = 1'b0;
      sof_err_d       = 1'b0;

      case (state_q)
         // IDLE shares the forwarding path: x/y are already 0 there, so an
         // in_sof pixel is simply the first PRIME pixel.
         S_IDLE, S_PRIME, S_TOP, S_STREAM: begin
            if (accept && (state_q != S_IDLE || bus.in_sof)) begin
               buf_pix_d       = bus.in_pix;
               buf_pix_valid_d = 1'b1;
               sel_top_d       = (state_q == S_TOP);
               sel_btm_d       = '0;
               col_valid_d     = (state_q == S_TOP) || (state_q == S_STREAM);
               col_x_d         = x_q;
               col_y_d         = (state_q == S_STREAM) ? (y_q - YW'(3)) : '0;
               col_eol_d       = col_valid_d && row_end;
               sof_err_d       = bus.in_sof && (state_q != S_IDLE);
               x_d             = row_end ? '0 : x_q + XW'(1);
               if (state_q == S_IDLE) begin
                  state_d = S_PRIME;
               end
               if (row_end) begin
                  y_d = y_q + YW'(1);
                  if (state_q == S_PRIME && y_q == YW'(2)) begin
                     state_d = S_TOP;
                  end else if (state_q == S_TOP) begin
                     state_d = S_STREAM;
                  end else if (state_q == S_STREAM && y_q == Y_LAST) begin
                     state_d = S_FLUSH;
                     y_d     = '0;
                     k_d     = 2'd1;
                  end
               end
            end
         end
         S_FLUSH: begin
            buf_pix_d       = '0;
            buf_pix_valid_d = 1'b1;
            sel_top_d       = 1'b0;
            sel_btm_d       = k_q;
            col_valid_d     = 1'b1;
            col_x_d         = x_q;
            col_y_d         = YW'(NUM_ROWS - 4) + YW'(k_q);
            col_eol_d       = row_end;
            col_eof_d       = row_end && (k_q == 2'd3);
            x_d             = row_end ? '0 : x_q + XW'(1);
            if (row_end) begin
               if (k_q == 2'd3) begin
                  k_d     = '0;
                  state_d = S_DONE;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
         end
         S_DONE: begin
            frame_done_d = 1'b1;
            sel_top_d    = 1'b0;
            sel_btm_d    = '0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d != S_FLUSH) && (state_d != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         x_q             <= '0;
         y_q             <= '0;
         k_q             <= '0;
         in_ready_q      <= 1'b1;
         buf_pix_q       <= '0;
         buf_pix_valid_q <= 1'b0;
         sel_top_q       <= 1'b0;
         sel_btm_q       <= '0;
         col_valid_q     <= 1'b0;
         col_x_q         <= '0;
         col_y_q         <= '0;
         col_eol_q       <= 1'b0;
         col_eof_q       <= 1'b0;
         frame_done_q    <= 1'b0;
         sof_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         x_q             <= x_d;
         y_q             <= y_d;
         k_q             <= k_d;
         in_ready_q      <= in_ready_d;
         buf_pix_q       <= buf_pix_d;
         buf_pix_valid_q <= buf_pix_valid_d;
         sel_top_q       <= sel_top_d;
         sel_btm_q       <= sel_btm_d;
         col_valid_q     <= col_valid_d;
         col_x_q         <= col_x_d;
         col_y_q         <= col_y_d;
         col_eol_q       <= col_eol_d;
         col_eof_q       <= col_eof_d;
         frame_done_q    <= frame_done_d;
         sof_err_q       <= sof_err_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.buf_pix       = buf_pix_q;
   assign bus.buf_pix_valid = buf_pix_valid_q;
   assign bus.sel_top_row   = sel_top_q;
   assign bus.sel_btm_row   = sel_btm_q;
   assign bus.col_valid     = col_valid_q;
   assign bus.col_x         = col_x_q;
   assign bus.col_y         = col_y_q;
   assign bus.col_eol       = col_eol_q;
   assign bus.col_eof       = col_eof_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.sof_err       = sof_err_q;
endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Bench for row_buffer_ctrl on a 4x8 frame: scenario table plus reset/back-to-back
// sequences, with every emitted beat scored against a per-frame expected stream.
module tb_row_buffer_ctrl;
   localparam int RW = 4;
   localparam int NR = 8;
   localparam int PB = 8;
   localparam int XW = 2;
   localparam int YW = 3;
   localparam int NPIX = RW * NR;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   row_buffer_ctrl_if #(.PIX_BIT(PB), .XW(XW), .YW(YW)) bus ();

   row_buffer_ctrl #(
      .ROW_WIDTH(RW), .NUM_ROWS(NR), .PIX_BIT(PB), .MASK_WIDTH(7)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct packed {
      logic [7:0] pix;
      logic       top;
      logic [1:0] btm;
      logic       cv;
      logic [1:0] cx;
      logic [2:0] cy;
      logic       eol;
      logic       eof;
      logic       serr;
   } beat_t;

   typedef struct {
      int gap;      // 0 none, 1 drop every third cycle, 2 random gaps
      int junk;     // pixels offered without in_sof before the frame
      int resof;    // pixel index carrying a stray in_sof, -1 for none
      int rnd;      // random pixel values
      int exp_bpv;
      int exp_cv;
      int exp_top;
      int exp_serr;
      int exp_flush;
   } vec_t;

   beat_t      exp_q[$];
   logic [7:0] frame_pix [NPIX];
   int checks = 0, failures = 0;
   int bpv_cnt, cv_cnt, top_cnt, serr_cnt, flush_cnt, flush_gap, done_cnt;
   int gap_ctr = 0;
   logic prev_eof = 1'b0;

   function automatic void chk(input string name, input logic ok,
                               input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   function automatic void clear_counts();
      bpv_cnt = 0; cv_cnt = 0; top_cnt = 0; serr_cnt = 0;
      flush_cnt = 0; flush_gap = 0; done_cnt = 0;
   endfunction

   // Reference stream: every image pixel in raster order, then three zero rows;
   // window centre row trails the input row by three.
   function automatic void push_frame(input int resof);
      beat_t r;
      for (int i = 0; i < NPIX; i++) begin
         int x, y;
         x = i % RW;
         y = i / RW;
         r.pix  = frame_pix[i];
         r.top  = (y == 3);
         r.btm  = 2'd0;
         r.cv   = (y >= 3);
         r.cx   = 2'(x);
         r.cy   = (y >= 3) ? 3'(y - 3) : 3'd0;
         r.eol  = r.cv && (x == RW - 1);
         r.eof  = 1'b0;
         r.serr = (i == resof);
         exp_q.push_back(r);
      end
      for (int k = 1; k <= 3; k++) begin
         for (int x = 0; x < RW; x++) begin
            r.pix  = 8'd0;
            r.top  = 1'b0;
            r.btm  = 2'(k);
            r.cv   = 1'b1;
            r.cx   = 2'(x);
            r.cy   = 3'(NR - 4 + k);
            r.eol  = (x == RW - 1);
            r.eof  = (k == 3) && (x == RW - 1);
            r.serr = 1'b0;
            exp_q.push_back(r);
         end
      end
   endfunction

   always @(negedge clk) begin
      beat_t act, e;
      if (!reset) begin
         act = {bus.buf_pix, bus.sel_top_row, bus.sel_btm_row, bus.col_valid, bus.col_x,
                bus.col_y, bus.col_eol, bus.col_eof, bus.sof_err};
         if (bus.buf_pix_valid) begin
            bpv_cnt++;
            if (bus.col_valid) cv_cnt++;
            if (bus.sel_top_row) top_cnt++;
            if (bus.sof_err) serr_cnt++;
            if (bus.sel_btm_row != 2'd0) flush_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1'b0, 64'(act), 64'd0);
            end else begin
               e = exp_q.pop_front();
               if (!e.cv) begin
                  e.cx = act.cx;
                  e.cy = act.cy;
               end
               chk("beat", act == e, 64'(act), 64'(e));
            end
         end else begin
            chk("idle_quiet", !(bus.col_valid || bus.col_eol || bus.col_eof || bus.sof_err),
                64'({bus.col_valid, bus.col_eol, bus.col_eof, bus.sof_err}), 64'd0);
            if (bus.sel_btm_row != 2'd0) flush_gap++;
         end
         chk("sel_exclusive", !(bus.sel_top_row && bus.sel_btm_row != 2'd0),
             64'({bus.sel_top_row, bus.sel_btm_row}), 64'd0);
         if (bus.frame_done) begin
            done_cnt++;
            chk("done_after_eof", prev_eof, 64'(prev_eof), 64'd1);
         end
         prev_eof = bus.col_valid && bus.col_eof;
      end else begin
         prev_eof = 1'b0;
      end
   end

   // Offers one pixel until accepted; waited returns cycles spent with in_ready low.
   task automatic send_pixel(input logic [7:0] pix, input logic sof, input int gap,
                             output int waited);
      waited = 0;
      if (gap == 2) begin
         while ($urandom_range(0, 99) < 30) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      bus.in_pix   = pix;
      bus.in_sof   = sof;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 50) begin
         waited++;
         @(posedge clk); #1;
      end
      if (waited >= 50) chk("accept_timeout", 1'b0, 64'(waited), 64'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      if (gap == 1) begin
         if (gap_ctr % 2 == 1) begin
            @(posedge clk); #1;
         end
         gap_ctr++;
      end
   endtask

   task automatic wait_done(input int n);
      for (int c = 0; c < 60 && done_cnt < n; c++) begin
         @(posedge clk); #1;
      end
      chk("frame_done_seen", done_cnt == n, 64'(done_cnt), 64'(n));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic fill_pix(input int rnd);
      for (int i = 0; i < NPIX; i++) frame_pix[i] = rnd ? 8'($urandom) : 8'(i);
   endtask

   task automatic run_frame(input vec_t v);
      int w;
      fill_pix(v.rnd);
      clear_counts();
      gap_ctr = 0;
      push_frame(v.resof);
      for (int j = 0; j < v.junk; j++) send_pixel(8'($urandom), 1'b0, v.gap, w);
      for (int i = 0; i < NPIX; i++)
         send_pixel(frame_pix[i], (i == 0) || (i == v.resof), v.gap, w);
      wait_done(1);
   endtask

   task automatic check_counts(input vec_t v);
      chk("bpv_count", bpv_cnt == v.exp_bpv, 64'(bpv_cnt), 64'(v.exp_bpv));
      chk("col_valid_count", cv_cnt == v.exp_cv, 64'(cv_cnt), 64'(v.exp_cv));
      chk("sel_top_count", top_cnt == v.exp_top, 64'(top_cnt), 64'(v.exp_top));
      chk("sof_err_count", serr_cnt == v.exp_serr, 64'(serr_cnt), 64'(v.exp_serr));
      chk("flush_count", flush_cnt == v.exp_flush, 64'(flush_cnt), 64'(v.exp_flush));
      chk("flush_no_gap", flush_gap == 0, 64'(flush_gap), 64'd0);
      chk("stream_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      vec_t vecs[5];
      int   w;
      logic seen;
      vecs[0] = '{gap: 0, junk: 0, resof: -1, rnd: 0, exp_bpv: 44, exp_cv: 32, exp_top: 4, exp_serr: 0, exp_flush: 12};
      vecs[1] = '{gap: 1, junk: 0, resof: -1, rnd: 0, exp_bpv: 44, exp_cv: 32, exp_top: 4, exp_serr: 0, exp_flush: 12};
      vecs[2] = '{gap: 0, junk: 5, resof: -1, rnd: 0, exp_bpv: 44, exp_cv: 32, exp_top: 4, exp_serr: 0, exp_flush: 12};
      vecs[3] = '{gap: 0, junk: 0, resof: 20, rnd: 0, exp_bpv: 44, exp_cv: 32, exp_top: 4, exp_serr: 1, exp_flush: 12};
      vecs[4] = '{gap: 2, junk: 3, resof: -1, rnd: 1, exp_bpv: 44, exp_cv: 32, exp_top: 4, exp_serr: 0, exp_flush: 12};

      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_pix   = '0;
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {bus.buf_pix, bus.buf_pix_valid, bus.sel_top_row, bus.sel_btm_row, bus.col_valid,
           bus.col_x, bus.col_y, bus.col_eol, bus.col_eof, bus.frame_done, bus.sof_err,
           bus.in_ready} == 25'd1,
          64'({bus.buf_pix, bus.buf_pix_valid, bus.sel_top_row, bus.sel_btm_row,
               bus.col_valid, bus.col_x, bus.col_y, bus.col_eol, bus.col_eof,
               bus.frame_done, bus.sof_err, bus.in_ready}), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int t = 0; t < 5; t++) begin
         run_frame(vecs[t]);
         check_counts(vecs[t]);
      end

      // Reset while the second flush row is being emitted.
      fill_pix(0);
      clear_counts();
      push_frame(-1);
      for (int i = 0; i < NPIX; i++) send_pixel(frame_pix[i], i == 0, 0, w);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (bus.sel_btm_row == 2'd2) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("reach_flush_row2", seen, 64'(seen), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_in_flush",
          {bus.buf_pix, bus.buf_pix_valid, bus.sel_top_row, bus.sel_btm_row, bus.col_valid,
           bus.col_x, bus.col_y, bus.col_eol, bus.col_eof, bus.frame_done, bus.sof_err,
           bus.in_ready} == 25'd1,
          64'({bus.buf_pix, bus.buf_pix_valid, bus.sel_top_row, bus.sel_btm_row,
               bus.col_valid, bus.col_x, bus.col_y, bus.col_eol, bus.col_eof,
               bus.frame_done, bus.sof_err, bus.in_ready}), 64'd1);
      reset = 1'b0;
      exp_q.delete();
      clear_counts();
      repeat (20) @(posedge clk);
      #1;
      chk("no_done_after_reset", done_cnt == 0, 64'(done_cnt), 64'd0);
      run_frame(vecs[0]);
      check_counts(vecs[0]);

      // Back-to-back frames with the next in_sof offered straight after the last pixel.
      fill_pix(0);
      clear_counts();
      push_frame(-1);
      push_frame(-1);
      for (int i = 0; i < NPIX; i++) send_pixel(frame_pix[i], i == 0, 0, w);
      send_pixel(frame_pix[0], 1'b1, 0, w);
      chk("ready_low_cycles", w == 13, 64'(w), 64'd13);
      for (int i = 1; i < NPIX; i++) send_pixel(frame_pix[i], 1'b0, 0, w);
      wait_done(2);
      chk("b2b_bpv_count", bpv_cnt == 88, 64'(bpv_cnt), 64'd88);
      chk("b2b_col_valid_count", cv_cnt == 64, 64'(cv_cnt), 64'd64);
      chk("b2b_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/row_buffer_ctrl.md
Name: row_buffer_ctrl

Overview:
- Sequencing controller for the 7x7 row-buffer array on the upstream (write) side.
- Accepts a raster pixel stream with a valid/ready handshake and forwards pixels to the array.
- Generates the top-border and bottom-border mirror selects, then inserts three flush rows at end of frame so that every image row is emitted as a window centre.
- Tags each emitted column with valid, coordinates and end-of-line/end-of-frame flags for the downstream window/kernel stage.

Parameters:
- ROW_WIDTH, 340: pixels per image row (>=4).
- NUM_ROWS, 240: rows per frame (>=7).
- PIX_BIT, 8: bits per pixel.
- MASK_WIDTH, 7: mask size; only 7 is supported. Elaboration fails otherwise.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_pix  in  PIX_BIT  upstream pixel.
- in_valid  in  1  upstream pixel valid.
- in_sof  in  1  marks first pixel of a frame; qualified by in_valid.
- in_ready  out  1  controller accepts in_pix this cycle.
- buf_pix  out  PIX_BIT  pixel into the row-buffer array.
- buf_pix_valid  out  1  array shifts exactly once in each cycle this is high.
- sel_top_row  out  1  top-border mirror select.
- sel_btm_row  out  2  bottom-border mirror select.
- col_valid  out  1  array column output is a valid window column this cycle.
- col_x  out  clog2(ROW_WIDTH)  column index of the valid column.
- col_y  out  clog2(NUM_ROWS)  centre row index of the valid column.
- col_eol  out  1  last column of a row (qualified by col_valid).
- col_eof  out  1  last column of the frame (qualified by col_valid).
- frame_done  out  1  one-cycle pulse after the final flush column.
- sof_err  out  1  one-cycle pulse: in_sof seen while a frame is in progress.

Behaviour:
- Reset:
  - State goes to IDLE; x, y and flush counters are cleared.
  - All outputs are 0 except in_ready=1.
  - Reset asserted mid-frame abandons the frame: no frame_done, and the next frame needs in_sof.
- Accept: a pixel is accepted when in_valid && in_ready.
- Registered outputs: all outputs are registered. buf_pix, buf_pix_valid, the selects and the col_* tags appear one cycle after acceptance, mutually aligned.
- Counters: x counts 0..ROW_WIDTH-1 per buf_pix_valid cycle and wraps to 0. y is incremented on the x wrap.
- States:
  - IDLE: in_ready=1. Pixels without in_sof are accepted and dropped (buf_pix_valid=0). An accepted pixel with in_sof is forwarded as x=0, y=0 and the state goes to PRIME.
  - PRIME (input rows 0..2): forward pixels, selects=0, col_valid=0. At the end of row 2, go to TOP.
  - TOP (input row 3): sel_top_row=1, sel_btm_row=0, col_valid=1, col_y=0. At end of row, go to STREAM.
  - STREAM (input rows 4..NUM_ROWS-1): selects=0, col_valid=1, col_y=y-3. After the last pixel of row NUM_ROWS-1, go to FLUSH.
  - FLUSH (3 rows, k=1..3):
    - in_ready=0; buf_pix=0 and buf_pix_valid=1 every cycle (no bubbles).
    - sel_btm_row=k, col_valid=1, col_y=NUM_ROWS-4+k.
    - After 3*ROW_WIDTH cycles, go to DONE.
  - DONE: frame_done=1 for one cycle, in_ready=0, then go to IDLE.
- Gaps: in_valid gaps during PRIME/TOP/STREAM give buf_pix_valid=0 (array holds); counters and selects freeze.
- Column count:
  - Exactly NUM_ROWS*ROW_WIDTH col_valid cycles per frame.
  - Exactly (NUM_ROWS+3)*ROW_WIDTH buf_pix_valid cycles per frame.
- Flags:
  - col_eol = col_valid && x==ROW_WIDTH-1.
  - col_eof = col_eol && col_y==NUM_ROWS-1, i.e. the last FLUSH cycle.
- Mid-frame in_sof: an in_sof accepted outside IDLE is treated as an ordinary pixel and sof_err pulses for one cycle.
- Back-to-back frames: the next frame's in_sof is only accepted after DONE, since in_ready=0 through FLUSH/DONE.
- Select stability: selects change only on row boundaries. sel_top_row and sel_btm_row!=0 are never asserted together.

Test Plan:
- ROW_WIDTH=4, NUM_ROWS=8; one frame of 32 pixels, pixel value = 4*y+x, in_valid held high -> 44 buf_pix_valid cycles, 32 col_valid cycles. sel_top_row high for exactly the 4 cycles carrying pixels 12..15. sel_btm_row sequence 1,1,1,1,2,2,2,2,3,3,3,3. frame_done high in the cycle after col_eof.
- Same frame with in_valid deasserted every third cycle -> identical buf_pix sequence and col_x/col_y tags with holes aligned to the gaps. Flush phase still has 12 contiguous cycles.
- 5 pixels without in_sof in IDLE, then a frame -> the 5 pixels are consumed with buf_pix_valid=0. The frame output is identical to scenario 1.
- in_sof reasserted on pixel 20 -> sof_err pulses one cycle, pixel forwarded as x=0, y=5, frame completes normally.
- reset asserted while in FLUSH (sel_btm_row=2) -> next cycle: all outputs 0, in_ready=1, no frame_done. A following frame matches scenario 1 exactly.
- Two frames back-to-back with in_sof offered immediately after the first frame's last pixel -> in_ready=0 for 13 cycles (12 FLUSH + 1 DONE), then the second frame is accepted. Both frames produce identical tag streams.
